// File: rtl/instruction_decode_stage_pkg.sv
// rtl/instruction_decode_stage_pkg.sv - ISA constants, FSM state type and instruction class helpers
package sm_isa_pkg;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    VALID  = 2'd3
  } state_t;

  // Rn is read for every two-operand ALU instruction (MVN has only Rm)
  function automatic logic needs_a(input logic [2:0] opc, input logic [1:0] op);
    return (opc == OPC_ALU) && (op != ALU_MVN);
  endfunction

  // Rm is read by every ALU instruction and by register MOV
  function automatic logic needs_b(input logic [2:0] opc, input logic [1:0] op);
    return (opc == OPC_ALU) || ((opc == OPC_MOV) && (op == MOV_REG));
  endfunction

  // CMP only sets flags; MOV op 01/11 are unassigned encodings
  function automatic logic wr_en_of(input logic [2:0] opc, input logic [1:0] op);
    case (opc)
      OPC_ALU: return op != ALU_CMP;
      OPC_MOV: return (op == MOV_REG) || (op == MOV_IMM);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instruction_decode_stage_if.sv
// rtl/instruction_decode_stage_if.sv - instruction-in and decoded-bundle-out handshake bundle
interface instruction_decode_stage_if #(
  parameter int DW = 16,
  parameter int RW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [1:0]    alu_op;
  logic [1:0]    shift;
  logic [2:0]    cond;
  logic [DW-1:0] sximm5;
  logic [DW-1:0] sximm8;
  logic [RW-1:0] wr_num;
  logic          wr_en_req;
  logic [RW-1:0] rd_num;
  logic          rd_load_a;
  logic          rd_load_b;
  logic          illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, opcode, op, alu_op, shift, cond, sximm5, sximm8,
           wr_num, wr_en_req, rd_num, rd_load_a, rd_load_b, illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, opcode, op, alu_op, shift, cond, sximm5, sximm8,
           wr_num, wr_en_req, rd_num, rd_load_a, rd_load_b, illegal
  );
endinterface

// File: rtl/instruction_decode_stage_decode_fields.sv
// rtl/instruction_decode_stage_decode_fields.sv - field extraction and immediate sign extension
module decode_fields #(
  parameter int DW = 16
) (
  input  logic [15:0]   ir,
  output logic [2:0]    opcode,
  output logic [1:0]    op,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [1:0]    shift,
  output logic [2:0]    rm,
  output logic [DW-1:0] sximm5,
  output logic [DW-1:0] sximm8
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/instruction_decode_stage.sv
// rtl/instruction_decode_stage.sv - instruction register, read sequencing FSM and decoded outputs
module instruction_decode_stage
  import sm_isa_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input logic                    clk,
  input logic                    reset_n,
  instruction_decode_stage_if.slave bus
);

  if (RW != 3) begin : g_rw_check
    $error("RW must be 3 for the 16-bit encoding");
  end
  if (DW < 8 || DW > 64) begin : g_dw_check
    $error("DW must lie in 8..64");
  end

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   ir;
  logic [2:0]    opcode;
  logic [1:0]    op;
  logic [2:0]    rn;
  logic [2:0]    rd;
  logic [2:0]    rm;
  logic [1:0]    shift;
  logic [DW-1:0] sximm5;
  logic [DW-1:0] sximm8;
  logic          in_ready_c;
  logic          out_valid_c;
  logic [RW-1:0] rd_num_c;
  logic          rd_load_a_c;
  logic          rd_load_b_c;
  logic          accept;

  decode_fields #(.DW(DW)) u_fields (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .shift  (shift),
    .rm     (rm),
    .sximm5 (sximm5),
    .sximm8 (sximm8)
  );

  assign accept = bus.in_valid && in_ready_c;

  // State register and instruction register; IR only loads on an accepted handshake
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ir <= bus.in_instr;
      end
    end
  end

  // Next state and handshake/read strobes; the accept-time class comes from in_instr since IR is not loaded yet
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    rd_num_c    = '0;
    rd_load_a_c = 1'b0;
    rd_load_b_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if (needs_a(bus.in_instr[15:13], bus.in_instr[12:11])) begin
            state_nxt = READ_A;
          end else if (needs_b(bus.in_instr[15:13], bus.in_instr[12:11])) begin
            state_nxt = READ_B;
          end else begin
            state_nxt = VALID;
          end
        end
      end
      READ_A: begin
        rd_num_c    = RW'(rn);
        rd_load_a_c = 1'b1;
        state_nxt   = needs_b(opcode, op) ? READ_B : VALID;
      end
      READ_B: begin
        rd_num_c    = RW'(rm);
        rd_load_b_c = 1'b1;
        state_nxt   = VALID;
      end
      VALID: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.rd_num    = rd_num_c;
  assign bus.rd_load_a = rd_load_a_c;
  assign bus.rd_load_b = rd_load_b_c;

  assign bus.opcode    = opcode;
  assign bus.op        = op;
  assign bus.alu_op    = op;
  assign bus.cond      = rn;
  assign bus.shift     = shift;
  assign bus.sximm5    = sximm5;
  assign bus.sximm8    = sximm8;
  assign bus.wr_num    = ((opcode == OPC_MOV) && (op == MOV_IMM)) ? RW'(rn) : RW'(rd);
  assign bus.wr_en_req = wr_en_of(opcode, op);
  // Gated off in IDLE so the cleared IR (opcode 000) does not flag illegal out of reset
  assign bus.illegal   = (state != IDLE) && (opcode != OPC_ALU) && (opcode != OPC_MOV);

endmodule
